// File: rtl/xoodoo_pkg.sv
// Shared constants, types and helpers for the iterative Xoodoo permutation.
// Lanes are 32-bit words; lane (y,x) sits at flat index 4y+x.
package xoodoo_pkg;

    localparam int LANE_W      = 32;
    localparam int NLANES      = 12;
    localparam int STATE_W     = NLANES * LANE_W;
    localparam int NROUNDS_MAX = 12;

    localparam logic [LANE_W-1:0] RC_TAB [NROUNDS_MAX] = '{
        32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
    };

    typedef enum logic {IDLE, RUN} fsm_e;

    typedef logic [NLANES-1:0][LANE_W-1:0] lanes_t;

    // Flat lane index of plane y, column x; both wrap so callers can pass x+3 for x-1.
    function automatic int lane_idx(input int y, input int x);
        return 4 * (y % 3) + (x % 4);
    endfunction

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int n);
        return (v << n) | (v >> (LANE_W - n));
    endfunction

endpackage

// File: rtl/xoodoo_perm_if.sv
// Start/result handshake between the hash controller and the permutation core.
interface xoodoo_perm_if;
    import xoodoo_pkg::*;

    logic               xoodoo_enable;
    logic [STATE_W-1:0] state_in;
    logic [STATE_W-1:0] state_out;
    logic               xoodoo_complete;
    logic               busy;

    modport master (output xoodoo_enable, output state_in,
                    input  state_out, input xoodoo_complete, input busy);
    modport slave  (input  xoodoo_enable, input state_in,
                    output state_out, output xoodoo_complete, output busy);
endinterface

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
module xoodoo_round
    import xoodoo_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [LANE_W-1:0]  rc_i,
    output logic [STATE_W-1:0] state_o
);

    lanes_t a, th, rw, io, ch, re;
    logic [3:0][LANE_W-1:0] p, e;

    assign a = state_i;

    for (genvar x = 0; x < 4; x++) begin : g_col
        assign p[x] = a[lane_idx(0, x)] ^ a[lane_idx(1, x)] ^ a[lane_idx(2, x)];
        assign e[x] = rotl(p[(x + 3) % 4], 5) ^ rotl(p[(x + 3) % 4], 14);

        for (genvar y = 0; y < 3; y++) begin : g_row
            assign th[lane_idx(y, x)] = a[lane_idx(y, x)] ^ e[x];
            // chi uses the post-iota planes only; lanes never mix across columns here
            assign ch[lane_idx(y, x)] = io[lane_idx(y, x)] ^
                (~io[lane_idx(y + 1, x)] & io[lane_idx(y + 2, x)]);
        end

        assign rw[lane_idx(0, x)] = th[lane_idx(0, x)];
        assign rw[lane_idx(1, x)] = th[lane_idx(1, x + 3)];
        assign rw[lane_idx(2, x)] = rotl(th[lane_idx(2, x)], 11);

        assign re[lane_idx(0, x)] = ch[lane_idx(0, x)];
        assign re[lane_idx(1, x)] = rotl(ch[lane_idx(1, x)], 1);
        assign re[lane_idx(2, x)] = rotl(ch[lane_idx(2, x + 2)], 8);
    end

    assign io      = {rw[NLANES-1:1], rw[0] ^ rc_i};
    assign state_o = re;

endmodule

// File: rtl/xoodoo_perm.sv
// Iterative Xoodoo permutation: one round per clock through a single round core.
// The result has its own register so a new job can load while the last result is shown.
module xoodoo_perm
    import xoodoo_pkg::*;
#(
    parameter int NROUNDS = 12
) (
    input logic          clk,
    input logic          resetn,
    xoodoo_perm_if.slave bus
);

    localparam logic [3:0] RC_BASE = 4'(NROUNDS_MAX - NROUNDS);
    localparam logic [3:0] LAST    = 4'(NROUNDS - 1);

    fsm_e               fsm_q, fsm_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [STATE_W-1:0] st_q, st_d;
    logic [STATE_W-1:0] out_q, out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [STATE_W-1:0] rnd_out;
    logic [3:0]         rc_idx;
    logic               last, start;

    assign rc_idx = RC_BASE + cnt_q;
    assign last   = (fsm_q == RUN) && (cnt_q == LAST);
    assign start  = bus.xoodoo_enable && ((fsm_q == IDLE) || last);

    xoodoo_round u_round (
        .state_i (st_q),
        .rc_i    (RC_TAB[rc_idx]),
        .state_o (rnd_out)
    );

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        out_d  = out_q;
        done_d = 1'b0;
        busy_d = busy_q;
        if (fsm_q == RUN) begin
            st_d  = rnd_out;
            cnt_d = cnt_q + 4'd1;
            if (last) begin
                out_d  = rnd_out;
                done_d = 1'b1;
                fsm_d  = IDLE;
                cnt_d  = '0;
                busy_d = 1'b0;
            end
        end
        // A start in the final round overrides the working state only; out_d still takes the result.
        if (start) begin
            st_d   = bus.state_in;
            cnt_d  = '0;
            fsm_d  = RUN;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            st_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            out_q  <= out_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign bus.state_out       = out_q;
    assign bus.xoodoo_complete = done_q;
    assign bus.busy            = busy_q;

endmodule
